onehot_stream_encoder: RTL and testbench
========================================

Name: onehot_stream_encoder

Overview:
- Inverse of the 3-to-8 select decoder: converts an 8-bit request vector back into a stream of 3-bit indices.
- Accepts one vector per transaction over a valid/ready handshake.
- Emits the index of every set bit, one per accepted output beat, in priority order.
- Used where decoded select/request lines must be turned back into binary select codes for downstream muxing or logging.

Parameters:
- LSB_FIRST, 1: 1 = serve lowest set bit first (bit i ↔ index i); 0 = highest set bit first.
- CNT_W, 4: width of the popcount output; must hold 0..8.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
- in_valid  input  1  upstream vector available.
- in_ready  output  1  block can accept a vector this cycle.
- in_vec  input  8  request vector; bit i set means index i is requested.
- out_valid  output  1  out_idx holds a valid index.
- out_ready  input  1  downstream accepts the current beat.
- out_idx  output  3  binary index of the current served bit.
- out_last  output  1  current beat is the final index of this vector.
- out_cnt  output  CNT_W  popcount of the latched vector, held for the whole transaction.
- zero_drop  output  1  one-cycle pulse: an all-zero vector was accepted and discarded.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, mask=0, out_valid=0, out_idx=0, out_last=0, out_cnt=0, zero_drop=0.
  - in_ready=1 once reset is released.
- States: IDLE, SERVE.
- Input handshake: a vector is accepted on a rising edge with in_valid && in_ready.
- in_ready:
  - 1 in IDLE.
  - 1 in SERVE only in a cycle where out_valid && out_ready && out_last (back-to-back transfer).
  - 0 otherwise.
  - Combinational from state and out_ready.
- IDLE, accepted in_vec != 0:
  - mask<=in_vec, out_cnt<=popcount(in_vec), go to SERVE.
  - First out_valid is asserted the next cycle. Latency: 1 cycle from acceptance to first beat.
- IDLE, accepted in_vec == 0:
  - Stay in IDLE, zero_drop<=1 for exactly one cycle, no output beat, out_cnt<=0.
- SERVE, outputs:
  - out_valid=1.
  - out_idx = index of the priority bit of mask (lowest set bit if LSB_FIRST=1, else highest), registered.
  - out_last=1 iff exactly one bit remains in mask.
- SERVE, beat accepted (out_valid && out_ready):
  - Clear the served bit from mask.
  - If it was the last beat: go to IDLE, out_valid<=0.
  - If a new vector is accepted in the same cycle, it is loaded and handled exactly as in IDLE. SERVE resumes with out_valid=1 next cycle, no bubble. A zero vector here pulses zero_drop and returns to IDLE.
- Backpressure (SERVE, out_ready=0): out_valid, out_idx, out_last and mask hold stable. in_vec changes are ignored.
- Throughput: one index per cycle while out_ready=1. A vector with k set bits occupies exactly k output beats.
- out_idx and out_last are don't-care when out_valid=0, but must be driven to 0 in IDLE.
- in_vec with all 8 bits set:
  - out_cnt=8.
  - Beats 0..7 (LSB_FIRST=1) or 7..0 (LSB_FIRST=0).
  - out_last only on the 8th beat.
- Reset mid-transaction: the pending mask is discarded, outputs return to reset values immediately, and nothing is emitted after release.
- No combinational path from in_vec to any output. in_ready may depend combinationally on out_ready.

Test Plan:
- Reset then in_vec=8'b00000001, out_ready=1 → one beat next cycle: out_idx=0, out_last=1, out_cnt=1. Back to IDLE, in_ready=1.
- in_vec=8'b10100100, out_ready=1, LSB_FIRST=1 → beats idx 2,5,7 on consecutive cycles, out_last only with 7, out_cnt=3. With LSB_FIRST=0 → idx 7,5,2.
- in_vec=8'b11111111 with out_ready toggling 1,0,1,0... → exactly 8 beats idx 0..7, values stable while out_ready=0, in_ready=0 until the last-beat handshake.
- in_vec=0 accepted → zero_drop high for 1 cycle, out_valid stays 0, in_ready stays 1.
- Back-to-back: vector 8'b00010000 then 8'b00000011 presented on the last-beat cycle → beats idx 4 (last), 0, 1 (last) with no idle gap.
- Assert reset=0 mid-stream of 8'b11110000 after 2 beats → out_valid=0 immediately, and after release no residual beats are emitted.

Source files
------------

// File: rtl/onehot_stream_encoder.sv
// Turns an 8-bit request vector into a stream of 3-bit indices, one per accepted beat,
// in priority order. Vectors arrive over a valid/ready handshake. Zero vectors are dropped.
module onehot_stream_encoder #(
    parameter bit LSB_FIRST = 1'b1,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_idx,
    output logic             out_last,
    output logic [CNT_W-1:0] out_cnt,
    output logic             zero_drop
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SERVE = 1'b1;

    logic [0:0] state;
    logic [7:0] mask;
    logic [7:0] mask_rest;
    logic       beat;
    logic       accept;

    // Priority bit: the scan order makes the last hit win.
    function automatic logic [2:0] prio_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (LSB_FIRST) begin
                if (v[7-i]) idx = 3'(7 - i);
            end else begin
                if (v[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [7:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < 8; i++) cnt = cnt + CNT_W'(v[i]);
        return cnt;
    endfunction

    function automatic logic is_single(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    assign out_valid = (state == SERVE);
    assign beat      = out_valid && out_ready;
    assign in_ready  = (state == IDLE) || (beat && out_last);
    assign accept    = in_valid && in_ready;
    assign mask_rest = mask & ~(8'd1 << out_idx);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mask      <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_cnt   <= '0;
            zero_drop <= 1'b0;
        end else begin
            zero_drop <= 1'b0;
            if (beat) begin
                // An emptied mask yields idx=0 and last=0, which is the IDLE output value.
                mask     <= mask_rest;
                out_idx  <= prio_idx(mask_rest);
                out_last <= is_single(mask_rest);
                if (out_last) state <= IDLE;
            end
            // NOTE: with non-blocking assignments the later statement wins, so a load
            // in the same cycle as the last beat cleanly overrides the drain above.
            if (accept) begin
                if (in_vec == 8'd0) begin
                    state     <= IDLE;
                    mask      <= '0;
                    out_idx   <= '0;
                    out_last  <= 1'b0;
                    out_cnt   <= '0;
                    zero_drop <= 1'b1;
                end else begin
                    state    <= SERVE;
                    mask     <= in_vec;
                    out_idx  <= prio_idx(in_vec);
                    out_last <= is_single(in_vec);
                    out_cnt  <= popcount(in_vec);
                end
            end
        end
    end

endmodule

// File: tb/tb_onehot_stream_encoder.sv
// Self-checking bench: two encoders (LSB-first and MSB-first) share one stimulus stream
// and are compared each cycle against a queue-based model of the expected index stream.
module tb_onehot_stream_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_vec;
    logic       out_ready;

    logic       l_in_ready, l_out_valid, l_out_last, l_zero_drop;
    logic [2:0] l_out_idx;
    logic [3:0] l_out_cnt;
    logic       m_in_ready, m_out_valid, m_out_last, m_zero_drop;
    logic [2:0] m_out_idx;
    logic [3:0] m_out_cnt;

    int checks   = 0;
    int failures = 0;

    logic [7:0] pend[$];
    int         q_l[$];
    int         q_m[$];
    int         m_cnt = 0;
    bit         m_zd  = 1'b0;

    always #5 clk = ~clk;

    onehot_stream_encoder #(.LSB_FIRST(1'b1), .CNT_W(4)) u_lsb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(l_in_ready),
        .in_vec(in_vec), .out_valid(l_out_valid), .out_ready(out_ready),
        .out_idx(l_out_idx), .out_last(l_out_last), .out_cnt(l_out_cnt),
        .zero_drop(l_zero_drop)
    );

    onehot_stream_encoder #(.LSB_FIRST(1'b0), .CNT_W(4)) u_msb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_vec(in_vec), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_idx(m_out_idx), .out_last(m_out_last), .out_cnt(m_out_cnt),
        .zero_drop(m_zero_drop)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs after the falling edge, compare, then advance the model
    // to what the coming rising edge should do.
    task automatic step(input logic v, input logic [7:0] vec, input logic rdy);
        bit exp_ir;
        bit acc;
        @(negedge clk);
        in_valid  = v;
        in_vec    = vec;
        out_ready = rdy;
        #1;
        exp_ir = (q_l.size() == 0) || (rdy && q_l.size() == 1);
        check("l_in_ready", l_in_ready, exp_ir);
        check("m_in_ready", m_in_ready, exp_ir);
        check("l_zero_drop", l_zero_drop, m_zd);
        check("m_zero_drop", m_zero_drop, m_zd);
        check("l_out_valid", l_out_valid, q_l.size() != 0);
        check("m_out_valid", m_out_valid, q_m.size() != 0);
        if (q_l.size() != 0) begin
            check("l_out_idx", l_out_idx, q_l[0]);
            check("l_out_last", l_out_last, q_l.size() == 1);
            check("l_out_cnt", l_out_cnt, m_cnt);
            check("m_out_idx", m_out_idx, q_m[0]);
            check("m_out_last", m_out_last, q_m.size() == 1);
            check("m_out_cnt", m_out_cnt, m_cnt);
        end
        if (m_zd) begin
            check("l_cnt_after_drop", l_out_cnt, 0);
            check("m_cnt_after_drop", m_out_cnt, 0);
        end
        if (q_l.size() != 0 && rdy) begin
            void'(q_l.pop_front());
            void'(q_m.pop_front());
        end
        acc  = v && exp_ir;
        m_zd = 1'b0;
        if (acc) begin
            if (pend.size() != 0) void'(pend.pop_front());
            if (vec == 8'd0) begin
                m_zd  = 1'b1;
                m_cnt = 0;
            end else begin
                m_cnt = 0;
                for (int i = 0; i < 8; i++) begin
                    if (vec[i]) begin
                        q_l.push_back(i);
                        m_cnt++;
                    end
                    if (vec[7-i]) q_m.push_back(7 - i);
                end
            end
        end
    endtask

    // mode 0: out_ready always 1; 1: toggles 1,0,1..; 2: random ready and random input gaps.
    task automatic drain(input int mode, input int budget);
        int n = 0;
        bit tog = 1'b1;
        logic rdy;
        bit gap;
        while ((pend.size() != 0 || q_l.size() != 0) && n < budget) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
            gap = (mode == 2) && ($urandom_range(0, 3) == 0);
            tog = !tog;
            if (pend.size() != 0 && !gap) step(1'b1, pend[0], rdy);
            else step(1'b0, 8'($urandom), rdy);
            n++;
        end
        check("drain_done", pend.size() + q_l.size(), 0);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = 8'd0;
        out_ready = 1'b0;
        #12;
        check("rst_l_valid", l_out_valid, 0);
        check("rst_l_idx", l_out_idx, 0);
        check("rst_l_last", l_out_last, 0);
        check("rst_l_cnt", l_out_cnt, 0);
        check("rst_l_zd", l_zero_drop, 0);
        check("rst_m_valid", m_out_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 8'd0, 1'b1);

        pend.push_back(8'b0000_0001);
        drain(0, 20);
        step(1'b0, 8'd0, 1'b1);

        pend.push_back(8'b1010_0100);
        drain(0, 20);

        pend.push_back(8'b1111_1111);
        drain(1, 40);

        pend.push_back(8'b0000_0000);
        drain(0, 10);
        step(1'b0, 8'd0, 1'b1);

        pend.push_back(8'b0001_0000);
        pend.push_back(8'b0000_0011);
        drain(0, 20);

        pend.push_back(8'b1111_1111);
        pend.push_back(8'b0000_0000);
        pend.push_back(8'b1000_0001);
        drain(2, 80);

        // Reset in the middle of a transaction, after two beats.
        pend.push_back(8'b1111_0000);
        for (int n = 0; n < 20 && !(pend.size() == 0 && q_l.size() == 2); n++) begin
            if (pend.size() != 0) step(1'b1, pend[0], 1'b1);
            else step(1'b0, 8'd0, 1'b1);
        end
        check("mid_rst_remaining", q_l.size(), 2);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_l_valid", l_out_valid, 0);
        check("mid_rst_m_valid", m_out_valid, 0);
        check("mid_rst_l_idx", l_out_idx, 0);
        check("mid_rst_l_last", l_out_last, 0);
        check("mid_rst_l_cnt", l_out_cnt, 0);
        q_l.delete();
        q_m.delete();
        pend.delete();
        m_zd  = 1'b0;
        m_cnt = 0;
        @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 6; n++) step(1'b0, 8'($urandom), 1'b1);

        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                0:       pend.push_back(8'd0);
                1:       pend.push_back(8'hFF);
                2:       pend.push_back(8'd1 << $urandom_range(0, 7));
                default: pend.push_back(8'($urandom));
            endcase
        end
        drain(2, 20000);
        drain(0, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
